// File: rtl/sd_spi_pkg.sv
// Shared constants for the SD card SPI master: register map, CTRL bit layout,
// transfer FSM encoding and the reset divider.
package sd_spi_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_DIV  = 2'd2;

    localparam int CTRL_NSS  = 0;
    localparam int CTRL_DONE = 6;
    localparam int CTRL_BUSY = 7;

    localparam logic [7:0] DIV_RESET_DEFAULT = 8'h1F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_t;

endpackage

// File: rtl/sd_spi_if.sv
// CPU-side register bus as seen by the SD SPI block (E-qualified, byte wide).
interface sd_spi_if;
    logic       E;
    logic       CS;
    logic       RnW;
    logic [1:0] ADDR;
    logic [7:0] DATA_in;
    logic [7:0] DATA_out;
    logic       DATA_oe;

    modport master (output E, CS, RnW, ADDR, DATA_in, input DATA_out, DATA_oe);
    modport slave  (input E, CS, RnW, ADDR, DATA_in, output DATA_out, DATA_oe);
endinterface

// File: rtl/sd_spi_shifter.sv
// tx/rx shift registers and bit counter, stepped by strobes from the SCLK FSM.
module spi_shifter (
    input  logic       clk_sys,
    input  logic       rst_b,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       sample,
    input  logic       shift,
    input  logic       finish,
    input  logic       miso,
    output logic       tx_msb,
    output logic       last_bit,
    output logic [7:0] rx_byte
);
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [2:0] bit_cnt;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            tx_sh   <= 8'h00;
            rx_sh   <= 8'h00;
            bit_cnt <= 3'd0;
            rx_byte <= 8'h00;
        end else begin
            if (load) begin
                tx_sh   <= load_data;
                bit_cnt <= 3'd0;
            end
            if (sample) rx_sh <= {rx_sh[6:0], miso};
            if (shift) begin
                tx_sh   <= {tx_sh[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            // rx_byte only changes once the whole byte is in, so reads stay stable mid-transfer
            if (finish) rx_byte <= rx_sh;
        end
    end

    assign tx_msb   = tx_sh[7];
    assign last_bit = (bit_cnt == 3'd7);
endmodule

// File: rtl/sd_spi.sv
// SPI mode-0 master for the SD socket: E-qualified register bus, programmable
// SCLK divider and a three-state bit-timing FSM.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no transfer, SCLK=0, MOSI=1
//   ST_LOW  | SCLK low half-period, MOSI=tx[7]
//   ST_HIGH | SCLK high half-period, MISO sampled on entry
module sd_spi
    import sd_spi_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = DIV_RESET_DEFAULT
) (
    input  logic    CLKX4,
    input  logic    nRESET,
    sd_spi_if.slave bus,
    output logic    SCLK,
    output logic    MOSI,
    input  logic    MISO,
    output logic    nSS
);
    spi_state_t state, state_nxt;
    logic       e_d, wr_q;
    logic [1:0] addr_q;
    logic [7:0] data_q, div, hcnt, rx_byte;
    logic       done, busy, commit, data_wr, start, expire;
    logic       sample, shift, finish, tx_msb, last_bit;

    // bus cycle is captured while E is high and committed on the E fall
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            e_d    <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= 2'd0;
            data_q <= 8'h00;
        end else begin
            e_d <= bus.E;
            if (bus.E) begin
                wr_q   <= bus.CS & ~bus.RnW;
                addr_q <= bus.ADDR;
                data_q <= bus.DATA_in;
            end
        end
    end

    assign commit  = e_d & ~bus.E & wr_q;
    assign data_wr = commit && (addr_q == ADDR_DATA);
    assign busy    = (state != ST_IDLE);
    assign start   = data_wr && !busy;
    assign expire  = (hcnt == 8'd0);

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            nSS  <= 1'b1;
            div  <= DIV_RESET;
            done <= 1'b0;
        end else begin
            if (commit && addr_q == ADDR_CTRL) nSS <= data_q[CTRL_NSS];
            if (commit && addr_q == ADDR_DIV)  div <= data_q;
            if (data_wr) done <= 1'b0;
            if (finish)  done <= 1'b1;
        end
    end

    // half-period timer reloads from the live divider on every phase entry
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET)                      hcnt <= DIV_RESET;
        else if (start || (busy && expire)) hcnt <= div;
        else if (busy)                    hcnt <= hcnt - 8'd1;
    end

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)  state_nxt = ST_LOW;
            ST_LOW:  if (expire) state_nxt = ST_HIGH;
            ST_HIGH: if (expire) state_nxt = last_bit ? ST_IDLE : ST_LOW;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        SCLK   = (state == ST_HIGH);
        MOSI   = (state == ST_IDLE) ? 1'b1 : tx_msb;
        sample = (state == ST_LOW)  && expire;
        shift  = (state == ST_HIGH) && expire && !last_bit;
        finish = (state == ST_HIGH) && expire && last_bit;
    end

    spi_shifter u_shifter (
        .clk_sys   (CLKX4),
        .rst_b     (nRESET),
        .load      (start),
        .load_data (data_q),
        .sample    (sample),
        .shift     (shift),
        .finish    (finish),
        .miso      (MISO),
        .tx_msb    (tx_msb),
        .last_bit  (last_bit),
        .rx_byte   (rx_byte)
    );

    assign bus.DATA_oe = bus.CS & bus.RnW & bus.E;

    always_comb begin
        bus.DATA_out = 8'h00;
        case (bus.ADDR)
            ADDR_DATA: bus.DATA_out = rx_byte;
            ADDR_CTRL: begin
                bus.DATA_out[CTRL_BUSY] = busy;
                bus.DATA_out[CTRL_DONE] = done;
                bus.DATA_out[CTRL_NSS]  = nSS;
            end
            ADDR_DIV:  bus.DATA_out = div;
            default:   bus.DATA_out = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_sd_spi.sv
// Directed + randomized bench for sd_spi with a bit-level model of the SPI frame.
module tb_sd_spi;
    import sd_spi_pkg::*;

    logic CLKX4 = 1'b0;
    logic nRESET = 1'b0;
    logic SCLK, MOSI, MISO, nSS;
    logic loop_en = 1'b0;
    logic miso_drv = 1'b1;
    logic exp_nss = 1'b1;
    int   errors = 0;
    int   checks = 0;

    sd_spi_if bus ();
    assign MISO = loop_en ? MOSI : miso_drv;

    sd_spi dut (
        .CLKX4  (CLKX4),
        .nRESET (nRESET),
        .bus    (bus.slave),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .nSS    (nSS)
    );

    always #5 CLKX4 = ~CLKX4;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLKX4);
        bus.E = 1'b1; bus.CS = 1'b1; bus.RnW = 1'b0; bus.ADDR = a; bus.DATA_in = d;
        repeat (2) @(negedge CLKX4);
        bus.E = 1'b0; bus.CS = 1'b0; bus.RnW = 1'b1; bus.ADDR = ADDR_CTRL;
    endtask

    task automatic bus_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
        @(negedge CLKX4);
        bus.E = 1'b1; bus.CS = 1'b1; bus.RnW = 1'b1; bus.ADDR = a;
        #1;
        check({tag, "/data"}, {24'h0, bus.DATA_out}, {24'h0, exp});
        check({tag, "/oe"}, {31'h0, bus.DATA_oe}, 32'd1);
        @(negedge CLKX4);
        bus.E = 1'b0; bus.CS = 1'b0; bus.ADDR = ADDR_CTRL;
    endtask

    // One full byte transfer; optional bus write injected at cycle inj_k of the frame.
    task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] div,
                        input logic lb, input logic [7:0] miso_byte, input int inj_k,
                        input logic [1:0] inj_a, input logic [7:0] inj_d);
        int period, total, rises, falls, busy_cyc, busy_pulses, timing_err, mosi_err;
        logic prev_sclk, busy_obs, b;
        logic [7:0] mosi_seq;
        period = int'(div) + 1;
        total = 16 * period;
        rises = 0; falls = 0; busy_cyc = 0; busy_pulses = 0; timing_err = 0; mosi_err = 0;
        prev_sclk = 1'b0; busy_obs = 1'b0; mosi_seq = 8'h00;
        loop_en = lb;
        miso_drv = miso_byte[7];
        bus_write(ADDR_DATA, tx);
        for (int k = 0; k < total + 4 * period + 8; k++) begin
            @(negedge CLKX4);
            b = (bus.ADDR == ADDR_CTRL) ? bus.DATA_out[CTRL_BUSY] : busy_obs;
            if (b && !busy_obs) busy_pulses++;
            if (b) busy_cyc++;
            if (b !== (k < total)) timing_err++;
            busy_obs = b;
            if (SCLK && !prev_sclk) begin
                if (k != (2 * rises + 1) * period) timing_err++;
                mosi_seq = {mosi_seq[6:0], MOSI};
                rises++;
                miso_drv = (rises < 8) ? miso_byte[7 - rises] : 1'b1;
            end
            if (!SCLK && prev_sclk) begin
                falls++;
                if (k != 2 * falls * period) timing_err++;
            end
            if (k < total && MOSI !== tx[7 - k / (2 * period)]) mosi_err++;
            if (k >= total && (SCLK !== 1'b0 || MOSI !== 1'b1)) timing_err++;
            prev_sclk = SCLK;
            if (k == inj_k) begin
                bus.E = 1'b1; bus.CS = 1'b1; bus.RnW = 1'b0; bus.ADDR = inj_a; bus.DATA_in = inj_d;
                if (inj_a == ADDR_CTRL) exp_nss = inj_d[CTRL_NSS];
            end
            if (k == inj_k + 2) begin
                bus.E = 1'b0; bus.CS = 1'b0; bus.RnW = 1'b1; bus.ADDR = ADDR_CTRL;
            end
        end
        check({tag, "/rises"}, rises, 8);
        check({tag, "/falls"}, falls, 8);
        check({tag, "/mosi_seq"}, {24'h0, mosi_seq}, {24'h0, tx});
        check({tag, "/busy_cycles"}, busy_cyc, total);
        check({tag, "/busy_pulses"}, busy_pulses, 1);
        check({tag, "/timing_err"}, timing_err, 0);
        check({tag, "/mosi_err"}, mosi_err, 0);
        bus_read({tag, "/rx"}, ADDR_DATA, lb ? tx : miso_byte);
        bus_read({tag, "/ctrl"}, ADDR_CTRL, {1'b0, 1'b1, 5'b0, exp_nss});
        loop_en = 1'b0;
        miso_drv = 1'b1;
    endtask

    initial begin
        int r;
        logic prev;
        logic [7:0] t, m, d;
        bus.E = 1'b0; bus.CS = 1'b0; bus.RnW = 1'b1; bus.ADDR = ADDR_CTRL; bus.DATA_in = 8'h00;

        // reset state
        repeat (3) @(negedge CLKX4);
        nRESET = 1'b1;
        @(negedge CLKX4);
        check("rst/sclk", {31'h0, SCLK}, 32'd0);
        check("rst/mosi", {31'h0, MOSI}, 32'd1);
        check("rst/nss", {31'h0, nSS}, 32'd1);
        check("rst/oe_idle", {31'h0, bus.DATA_oe}, 32'd0);
        bus_read("rst/ctrl", ADDR_CTRL, 8'h01);
        bus_read("rst/div", ADDR_DIV, 8'h1F);
        bus_read("rst/data", ADDR_DATA, 8'h00);

        // reserved offset
        bus_write(2'd3, 8'hFF);
        bus_read("rsv/read", 2'd3, 8'h00);
        bus_read("rsv/ctrl", ADDR_CTRL, 8'h01);
        bus_read("rsv/div", ADDR_DIV, 8'h1F);

        // loopback, fastest clock
        bus_write(ADDR_DIV, 8'h00);
        bus_read("lb/div", ADDR_DIV, 8'h00);
        xfer("loopback", 8'hA5, 8'h00, 1'b1, 8'h00, -10, ADDR_DATA, 8'h00);

        // slower divider, MISO held high
        bus_write(ADDR_DIV, 8'h03);
        bus_read("div/div", ADDR_DIV, 8'h03);
        xfer("divider", 8'h00, 8'h03, 1'b0, 8'hFF, -10, ADDR_DATA, 8'h00);

        // second DATA write mid-transfer must be ignored
        bus_write(ADDR_DIV, 8'h01);
        xfer("wr_busy", 8'hC3, 8'h01, 1'b1, 8'h00, 12, ADDR_DATA, 8'h3C);

        // randomized bytes and dividers
        for (int i = 0; i < 4; i++) begin
            t = 8'($urandom);
            m = 8'($urandom);
            d = 8'($urandom_range(2, 0));
            bus_write(ADDR_DIV, d);
            xfer($sformatf("rand%0d", i), t, d, 1'b0, m, -10, ADDR_DATA, 8'h00);
        end

        // software nSS control, including a CTRL write mid-transfer
        bus_write(ADDR_CTRL, 8'h00);
        exp_nss = 1'b0;
        @(negedge CLKX4);
        check("nss/low", {31'h0, nSS}, 32'd0);
        bus_read("nss/ctrl_low", ADDR_CTRL, 8'h40);
        bus_write(ADDR_DIV, 8'h00);
        xfer("nss_xfer", 8'h5A, 8'h00, 1'b1, 8'h00, 6, ADDR_CTRL, 8'h01);
        check("nss/high", {31'h0, nSS}, 32'd1);

        // asynchronous reset mid-transfer
        bus_write(ADDR_DIV, 8'h01);
        bus_write(ADDR_DATA, 8'hC3);
        r = 0;
        prev = 1'b0;
        for (int k = 0; k < 200 && r < 3; k++) begin
            @(negedge CLKX4);
            if (SCLK && !prev) r++;
            prev = SCLK;
        end
        check("mid_rst/pulses_seen", r, 3);
        #2;
        nRESET = 1'b0;
        #1;
        check("mid_rst/sclk", {31'h0, SCLK}, 32'd0);
        check("mid_rst/mosi", {31'h0, MOSI}, 32'd1);
        check("mid_rst/nss", {31'h0, nSS}, 32'd1);
        bus_read("mid_rst/ctrl", ADDR_CTRL, 8'h01);
        bus_read("mid_rst/data", ADDR_DATA, 8'h00);
        @(negedge CLKX4);
        nRESET = 1'b1;
        bus_read("mid_rst/div", ADDR_DIV, 8'h1F);
        r = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLKX4);
            if (SCLK !== 1'b0 || MOSI !== 1'b1) r++;
        end
        check("mid_rst/quiet", r, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sd_spi.md
# sd_spi

SPI master for the SD card socket, sitting directly downstream of the CPLD address decoder: the decoder's SD chip-select strobe and the CPU bus feed three byte-wide registers here, and this block drives SCLK, MOSI and nSS and samples MISO. It runs on CLKX4, the 4x clock that also generates E/Q. It qualifies CPU cycles with E, so register writes commit in the CLKX4 domain at the E falling edge. Transfers are 8-bit, SPI mode 0, with a programmable SCLK divider so one block covers both the slow SD init clock and full-speed data.

## Interface
- DIV_RESET, 8'h1F: divider value loaded at reset; SCLK half-period = DIV+1 CLKX4 cycles.
- CLKX4  input  1  system clock, 4x CPU E.
- nRESET  input  1  asynchronous, active-low reset.
- E  input  1  CPU E clock, synchronous to CLKX4; a bus cycle is valid while E=1.
- CS  input  1  register select from the address decoder, valid while E=1.
- RnW  input  1  CPU read/not-write.
- ADDR  input  2  register offset: 0 DATA, 1 CTRL, 2 DIV, 3 reserved.
- DATA_in  input  8  CPU write data.
- DATA_out  output  8  CPU read data.
- DATA_oe  output  1  CS & RnW & E.
- SCLK  output  1  SPI clock; idles low.
- MOSI  output  1  SPI data out; idles high.
- MISO  input  1  SPI data in.
- nSS  output  1  SD card select; software controlled.

## Operation
- Write commit: edge detector e_d registered on CLKX4; commit when e_d=1, E=0, and CS & !RnW were captured on the previous cycle. Data and offset are latched while E=1.
- DATA write, not busy: load tx shift register, clear bit counter, set BUSY, enter LOW.
- DATA write while BUSY: ignored completely; the shift register and counter are unchanged.
- DATA read: returns rx register, the last completed byte. During BUSY it still returns the previous byte.
- CTRL: bit0 nSS (R/W, reset 1); bit7 BUSY (read-only); bit6 DONE (read-only), set at transfer end and cleared by any DATA write commit; other bits read 0.
- DIV: 8-bit R/W, reset DIV_RESET. A write during BUSY takes effect at the next half-period reload.
- Offset 3: reads 8'h00; writes ignored.
- FSM states:
  - IDLE: SCLK=0, MOSI=1.
  - LOW: SCLK=0, MOSI=tx[7], counts DIV+1 cycles, then goes to HIGH and samples MISO into rx[0] with a left shift.
  - HIGH: SCLK=1, counts DIV+1 cycles. At expiry:
    - bit counter=7: go to IDLE, clear BUSY, set DONE.
    - otherwise: shift tx left, increment bit counter, go to LOW.
- MSB first. Bit counter is 3 bits; the half-period counter is 8 bits and reloads with the current DIV on each state entry.
- nSS is never touched by hardware; software drives it through CTRL.

## Timing
- Reset values: SCLK=0, MOSI=1, nSS=1, BUSY=0, DONE=0, rx=8'h00, DIV=DIV_RESET, FSM=IDLE, DATA_oe=0.
- Reset asserted mid-transfer: all of the above return immediately (asynchronous); no partial byte is kept.
- Commit in CLKX4 cycle t (E falling edge seen): BUSY=1 and MOSI=bit7 from t+1. The first SCLK rise is at t+1+(DIV+1).
- Transfer length: exactly 16*(DIV+1) cycles from t+1. BUSY clears and SCLK is low in the same cycle the last HIGH phase expires.
- MISO is sampled on the CLKX4 edge that raises SCLK.
- DIV=0: SCLK=CLKX4/2, the fastest setting; a transfer takes 16 cycles.
- DATA_out is combinational from the registers. A CTRL read in the same E cycle as a DATA write commit shows BUSY=0, because the commit happens at the E fall.

## Structure
- Shared package sd_spi_pkg: register offsets (DATA=2'd0, CTRL=2'd1, DIV=2'd2), CTRL bit positions, FSM state encoding (IDLE, LOW, HIGH), DIV_RESET default.
- One natural sub-module: spi_shifter. It holds the tx/rx shift registers and bit counter, and is stepped by rise/fall strobes from the FSM.
- The bus interface, divider and FSM stay in sd_spi.

## Test plan
- Reset:
  - Stimulus: release nRESET.
  - Required: SCLK=0, MOSI=1, nSS=1, CTRL reads 8'h01, DIV reads 8'h1F.
- Loopback (MISO tied to MOSI, DIV=0):
  - Stimulus: write DATA=8'hA5.
  - Required: 8 SCLK pulses, MOSI stream 1,0,1,0,0,1,0,1; BUSY high for 16 cycles; then DATA reads 8'hA5 and CTRL reads 8'h41.
- Divider (DIV=8'h03, MISO held 1):
  - Stimulus: write DATA=8'h00.
  - Required: SCLK high and low each 4 cycles; total 64 cycles; DATA reads 8'hFF.
- Write while busy:
  - Stimulus: second DATA write (8'h3C) mid-transfer of 8'hC3.
  - Required: MOSI pattern stays 8'hC3; only one BUSY pulse; DONE set once.
- Reset mid-transfer:
  - Stimulus: assert nRESET after 3 SCLK pulses.
  - Required: SCLK=0 and MOSI=1 immediately; BUSY=0; rx=8'h00.
- nSS control:
  - Stimulus: write CTRL=8'h00, then CTRL=8'h01.
  - Required: nSS 0, then 1; the transfer FSM is unaffected.
